// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//   Pipelined two's-complement adder/subtractor. The operands are split into
//   STAGES equal slices of SW = WIDTH/STAGES bits. Stage k adds slice k with
//   the carry registered by stage k-1. The not-yet-consumed operand bits and
//   the already-computed lower result bits travel down the pipe with the op.
//   A single global enable stalls the whole pipe when the result is held.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth (= latency in cycles), >= 1
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle (low only while stalled)
//   a, b       operands
//   c_in       carry-in (add) / borrow-in (sub)
//   op_sub     0: a + b + c_in, 1: a - b - c_in
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   carry_out  raw carry out of the MSB (sub: 1 = no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
//   zero       sum == 0
// ---------------------------------------------------------------------------
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipelined_addsub: STAGES must be >= 1");
        end else if (WIDTH % STAGES != 0) begin : g_bad_width
            $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
        end
    endgenerate

    localparam int SW = WIDTH / STAGES;

    // Per-stage pipeline registers. r_a/r_b hold the operand bits not yet
    // consumed, shifted down so the next slice always sits at [SW-1:0].
    logic             r_v [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_ovf;
    logic             r_zero;

    logic             w_stall;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    // The whole pipe freezes while the final result waits for the consumer.
    assign w_stall  = r_v[STAGES-1] & ~out_ready;
    assign in_ready = ~w_stall;

    // Subtraction as a + ~b + ~c_in: inverting the borrow-in makes
    // a - b - c_in fit the same carry chain as the add.
    assign w_b0 = op_sub ? ~b : b;
    assign w_c0 = c_in ^ op_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_v_in;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_s_in;
        logic             w_c_in;
        logic [SW:0]      w_slice;
        logic [WIDTH-1:0] w_s_nxt;

        if (k == 0) begin : g_head
            assign w_v_in = in_valid;
            assign w_a_in = a;
            assign w_b_in = w_b0;
            assign w_c_in = w_c0;
            assign w_s_in = '0;
        end else begin : g_body
            assign w_v_in = r_v[k-1];
            assign w_a_in = r_a[k-1];
            assign w_b_in = r_b[k-1];
            assign w_c_in = r_c[k-1];
            assign w_s_in = r_s[k-1];
        end

        assign w_slice = {1'b0, w_a_in[SW-1:0]} + {1'b0, w_b_in[SW-1:0]}
                       + {{SW{1'b0}}, w_c_in};

        // NOTE: every variable written in always_comb gets a full default
        // first, so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            w_s_nxt               = w_s_in;
            w_s_nxt[k*SW +: SW]   = w_slice[SW-1:0];
        end

        // NOTE: sequential state uses non-blocking assignments only, so every
        // stage samples its predecessor's pre-edge value.
        // NOTE: the datapath registers are reset as well as the valid bits,
        // because the result fields must read zero straight out of reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end else if (!w_stall) begin
                r_v[k] <= w_v_in;
                r_a[k] <= w_a_in >> SW;
                r_b[k] <= w_b_in >> SW;
                r_s[k] <= w_s_nxt;
                r_c[k] <= w_slice[SW];
            end
        end

        if (k == STAGES-1) begin : g_tail
            // In the last stage the operand MSBs sit at bit SW-1, so the carry
            // into the MSB is recovered from the sum bit and the two inputs.
            logic w_msb_cin;
            assign w_msb_cin = w_a_in[SW-1] ^ w_b_in[SW-1] ^ w_slice[SW-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf  <= w_msb_cin ^ w_slice[SW];
                    r_zero <= ~|w_s_nxt;
                end
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign carry_out = r_c[STAGES-1];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub
//   Drives three configurations of pipelined_addsub (64/4, 32/1, 16/8) from a
//   shared clock/reset. A negedge monitor predicts every accepted op with an
//   arithmetic reference model and matches results in order; directed
//   sequences cover latency, back-to-back issue, stall and reset.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub;

    localparam int ND = 3;
    localparam int WV [ND] = '{64, 32, 16};
    localparam int SV [ND] = '{4, 1, 8};

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic        sub;
        logic [63:0] e_sum;
        logic        e_co;
        logic        e_ov;
        logic        e_z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [ND];
    logic        op_sub    [ND];
    logic        c_in      [ND];
    logic        out_ready [ND];
    logic [63:0] a         [ND];
    logic [63:0] b         [ND];
    logic        in_ready  [ND];
    logic        out_valid [ND];
    logic        carry_out [ND];
    logic        overflow  [ND];
    logic        zero      [ND];
    logic [63:0] sum       [ND];
    logic [63:0] sum64;
    logic [31:0] sum32;
    logic [15:0] sum16;

    int n_checks = 0;
    int n_errors = 0;
    int n_out [ND];

    res_t        exp_q [ND][$];
    res_t        e_m;
    logic        held_stall [ND];
    logic [127:0] held [ND];
    vec_t        vt [6];

    always #5 clk = ~clk;

    assign sum[0] = sum64;
    assign sum[1] = {32'b0, sum32};
    assign sum[2] = {48'b0, sum16};

    pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .c_in(c_in[0]), .op_sub(op_sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum64), .carry_out(carry_out[0]), .overflow(overflow[0]), .zero(zero[0])
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][31:0]), .b(b[1][31:0]), .c_in(c_in[1]), .op_sub(op_sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum32), .carry_out(carry_out[1]), .overflow(overflow[1]), .zero(zero[1])
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(8)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2][15:0]), .b(b[2][15:0]), .c_in(c_in[2]), .op_sub(op_sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum16), .carry_out(carry_out[2]), .overflow(overflow[2]), .zero(zero[2])
    );

    // Reference model: plain integer arithmetic on wide signed values.
    function automatic res_t model(int w, logic [63:0] av, logic [63:0] bv, logic cv, logic sv);
        res_t              m;
        logic [63:0]       mask;
        logic signed [67:0] ua, ub, uc, sa, sb, r_u, r_s, lim;
        mask = ~64'd0 >> (64 - w);
        ua   = $signed({4'b0, av & mask});
        ub   = $signed({4'b0, bv & mask});
        uc   = $signed({67'b0, cv});
        lim  = 68'sd1 <<< (w - 1);
        sa   = (ua >= lim) ? ua - (lim <<< 1) : ua;
        sb   = (ub >= lim) ? ub - (lim <<< 1) : ub;
        if (!sv) begin
            r_u  = ua + ub + uc;
            r_s  = sa + sb + uc;
            m.co = (r_u >= (lim <<< 1));
        end else begin
            r_u  = ua - ub - uc;
            r_s  = sa - sb - uc;
            m.co = (r_u >= 0);
        end
        m.ov  = (r_s >= lim) || (r_s < -lim);
        m.sum = r_u[63:0] & mask;
        m.z   = (m.sum == 64'd0);
        return m;
    endfunction

    function automatic logic [127:0] pack(logic v, res_t e);
        return {60'b0, v, e.sum, e.co, e.ov, e.z};
    endfunction

    function automatic logic [127:0] obs(int d);
        return {60'b0, out_valid[d], sum[d], carry_out[d], overflow[d], zero[d]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(int d, logic [63:0] av, logic [63:0] bv, logic cv, logic sv);
        a[d]      = av;
        b[d]      = bv;
        c_in[d]   = cv;
        op_sub[d] = sv;
    endtask

    function automatic logic [63:0] rand_operand(int w);
        logic [63:0] one;
        one = 64'd1;
        case ($urandom_range(0, 7))
            0:       return ~64'd0;
            1:       return (one << (w - 1)) - one;
            2:       return one << (w - 1);
            3:       return 64'd0;
            4:       return one;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op, confirm out_valid stays low for STAGES-1 cycles, then
    // compare the result fields in the cycle it appears.
    task automatic apply_vec(int d, vec_t v, logic [127:0] expv, string name);
        @(posedge clk); #1;
        drive(d, v.a, v.b, v.c, v.sub);
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        for (int j = 1; j < SV[d]; j++) begin
            @(negedge clk);
            check($sformatf("%s_early", name), {127'b0, out_valid[d]}, 128'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check(name, obs(d), expv);
    endtask

    // Monitor: predict on accept, match on output handshake, check held output.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                exp_q[d].delete();
                held_stall[d] = 1'b0;
            end else begin
                if (held_stall[d])
                    check($sformatf("hold%0d", d), obs(d), held[d]);
                if (out_valid[d] && out_ready[d]) begin
                    n_out[d]++;
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("spurious%0d", d), {127'b0, out_valid[d]}, 128'd0);
                    end else begin
                        e_m = exp_q[d].pop_front();
                        check($sformatf("stream%0d", d), obs(d), pack(1'b1, e_m));
                    end
                end
                held_stall[d] = out_valid[d] && !out_ready[d];
                held[d]       = obs(d);
                if (in_valid[d] && in_ready[d])
                    exp_q[d].push_back(model(WV[d], a[d], b[d], c_in[d], op_sub[d]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        int   n_before;
        vec_t ops [6];

        vt[0] = '{64'd738468, 64'd900000, 1'b1, 1'b0, 64'd1638469, 1'b0, 1'b0, 1'b0};
        vt[1] = '{64'd7446525, 64'd1000000, 1'b0, 1'b0, 64'd8446525, 1'b0, 1'b0, 1'b0};
        vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[5] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0};

        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            n_out[d]     = 0;
            drive(d, 64'd0, 64'd0, 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_out%0d", d), obs(d), 128'd0);
            check($sformatf("reset_in_ready%0d", d), {127'b0, in_ready[d]}, 128'd1);
        end

        // Directed table on the 64/4 configuration (fixed expected values)
        for (int i = 0; i < 6; i++)
            apply_vec(0, vt[i], {60'b0, 1'b1, vt[i].e_sum, vt[i].e_co, vt[i].e_ov, vt[i].e_z},
                      $sformatf("vec64_%0d", i));

        // Same vectors on 32/1 and 16/8, expected values from the model
        for (int d = 1; d < ND; d++)
            for (int i = 0; i < 6; i++)
                apply_vec(d, vt[i], pack(1'b1, model(WV[d], vt[i].a, vt[i].b, vt[i].c, vt[i].sub)),
                          $sformatf("vec%0d_%0d", WV[d], i));

        // Back-to-back issue: results on consecutive cycles, in order
        @(posedge clk); #1;
        drive(0, vt[0].a, vt[0].b, vt[0].c, vt[0].sub);
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        drive(0, vt[1].a, vt[1].b, vt[1].c, vt[1].sub);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (SV[0] - 2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b2b_first", obs(0), {60'b0, 1'b1, vt[0].e_sum, vt[0].e_co, vt[0].e_ov, vt[0].e_z});
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_second", obs(0), {60'b0, 1'b1, vt[1].e_sum, vt[1].e_co, vt[1].e_ov, vt[1].e_z});
        repeat (6) @(posedge clk);

        // Stream of 6 ops with a 5-cycle consumer stall mid-stream
        for (int i = 0; i < 6; i++)
            ops[i] = '{rand_operand(64), rand_operand(64), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 64'd0, 1'b0, 1'b0, 1'b0};
        idx      = 0;
        n_before = n_out[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            out_ready[0] = !(cyc >= 4 && cyc < 9);
            in_valid[0]  = (idx < 6);
            if (idx < 6) drive(0, ops[idx].a, ops[idx].b, ops[idx].c, ops[idx].sub);
            @(negedge clk);
            if (out_valid[0] && !out_ready[0])
                check("stall_in_ready", {127'b0, in_ready[0]}, 128'd0);
            if (in_valid[0] && in_ready[0]) idx++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        check("stall_issued", 128'(idx), 128'd6);
        check("stall_delivered", 128'(n_out[0] - n_before), 128'd6);
        check("stall_queue_empty", 128'(exp_q[0].size()), 128'd0);

        // Reset with three ops in flight
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive(0, rand_operand(64), rand_operand(64), 1'b0, 1'b0);
            in_valid[0] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        rst_n       = 1'b0;
        n_before    = n_out[0];
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("flush_out", obs(0), 128'd0);
        check("flush_in_ready", {127'b0, in_ready[0]}, 128'd1);
        repeat (10) @(posedge clk);
        check("flush_discarded", 128'(n_out[0] - n_before), 128'd0);

        // Randomized traffic with random backpressure on all configurations
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                out_ready[d] = ($urandom_range(0, 3) != 0);
                in_valid[d]  = ($urandom_range(0, 9) < 7);
                drive(d, rand_operand(WV[d]), rand_operand(WV[d]),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (20) @(posedge clk);
        for (int d = 0; d < ND; d++)
            check($sformatf("drain%0d", d), 128'(exp_q[d].size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
